multicycle_control: RTL and testbench

- Multicycle main control FSM for the RV64 datapath.
- Drives ALU_Op and the operand selects into alu_control/alu, and consumes the ALU zero flag for beq.
- Sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory port with a req/ack handshake.
- Supported opcodes: R-type, addi, ld, sd and beq. Also keeps a retired-instruction counter.

---
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle main control FSM for the RV64 datapath: fetch/decode/execute/memory/writeback
// over a shared req/ack memory port, plus a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [3:0] {
        StRst,
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StWbAlu,
        StMemAddr,
        StMemRd,
        StWbMem,
        StMemWr,
        StBranch,
        StTrap
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRst;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_op     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            StRst: state_d = StFetch;

            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC+4 are captured only in the cycle the fetch completes
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end

            StDecode: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OpR:              state_d = StExecR;
                    OpImm:            state_d = StExecI;
                    OpLoad, OpStore:  state_d = StMemAddr;
                    OpBranch:         state_d = StBranch;
                    default:          state_d = StTrap;
                endcase
            end

            StExecR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = StWbAlu;
            end

            StExecI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = StWbAlu;
            end

            StWbAlu: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end

            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OpLoad) ? StMemRd : StMemWr;
            end

            StMemRd: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ack) state_d = StWbMem;
            end

            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end

            StMemWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ack) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end

            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                // Branch target was precomputed into ALUOut during decode
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = StFetch;
            end

            StTrap: illegal = 1'b1;

            default: state_d = StRst;
        endcase
    end

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expected controls and
// retire counts, a negedge monitor pops and compares them.
module tb_multicycle_control;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpBad    = 7'b1111111;

    // {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_op, alu_src_a, alu_src_b,
    //  reg_write, mem_to_reg, illegal}
    localparam logic [13:0] C_RST   = 14'b0_0_0_0_0_0_00_0_00_0_0_0;
    localparam logic [13:0] C_FETCH = 14'b1_0_0_0_0_0_00_0_01_0_0_0;
    localparam logic [13:0] C_FACK  = 14'b1_0_0_1_1_0_00_0_01_0_0_0;
    localparam logic [13:0] C_DEC   = 14'b0_0_0_0_0_0_00_0_10_0_0_0;
    localparam logic [13:0] C_EXR   = 14'b0_0_0_0_0_0_10_1_00_0_0_0;
    localparam logic [13:0] C_EXI   = 14'b0_0_0_0_0_0_00_1_10_0_0_0;
    localparam logic [13:0] C_WBA   = 14'b0_0_0_0_0_0_00_0_00_1_0_0;
    localparam logic [13:0] C_MADDR = 14'b0_0_0_0_0_0_00_1_10_0_0_0;
    localparam logic [13:0] C_MRD   = 14'b1_0_1_0_0_0_00_0_00_0_0_0;
    localparam logic [13:0] C_WBM   = 14'b0_0_0_0_0_0_00_0_00_1_1_0;
    localparam logic [13:0] C_MWR   = 14'b1_1_1_0_0_0_00_0_00_0_0_0;
    localparam logic [13:0] C_BRT   = 14'b0_0_0_0_1_1_01_1_00_0_0_0;
    localparam logic [13:0] C_BRN   = 14'b0_0_0_0_0_1_01_1_00_0_0_0;
    localparam logic [13:0] C_TRAP  = 14'b0_0_0_0_0_0_00_0_00_0_0_1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;

    logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
    logic [1:0]  alu_op, alu_src_b;
    logic        alu_src_a, reg_write, mem_to_reg, illegal;
    logic [63:0] instret;

    logic        n_mem_req, n_mem_we, n_i_or_d, n_ir_write, n_pc_write, n_pc_src;
    logic [1:0]  n_alu_op, n_alu_src_b;
    logic        n_alu_src_a, n_reg_write, n_mem_to_reg, n_illegal;
    logic [3:0]  n_instret;

    typedef struct {
        string       name;
        logic [13:0] ctl;
        int unsigned cnt;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cnt = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .i_or_d    (i_or_d),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .reg_write (reg_write),
        .mem_to_reg(mem_to_reg),
        .illegal   (illegal),
        .instret   (instret)
    );

    multicycle_control #(.CNT_W(4)) dut_n (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ack   (mem_ack),
        .mem_req   (n_mem_req),
        .mem_we    (n_mem_we),
        .i_or_d    (n_i_or_d),
        .ir_write  (n_ir_write),
        .pc_write  (n_pc_write),
        .pc_src    (n_pc_src),
        .alu_op    (n_alu_op),
        .alu_src_a (n_alu_src_a),
        .alu_src_b (n_alu_src_b),
        .reg_write (n_reg_write),
        .mem_to_reg(n_mem_to_reg),
        .illegal   (n_illegal),
        .instret   (n_instret)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per clock, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, ".ctl"}, 64'({mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                                         alu_op, alu_src_a, alu_src_b, reg_write, mem_to_reg,
                                         illegal}), 64'(e.ctl));
            check({e.name, ".instret"}, instret, 64'(e.cnt));
            check({e.name, ".instret4"}, 64'(n_instret), 64'(e.cnt[3:0]));
        end
    end

    task automatic push(input string name, input logic [13:0] ctl);
        exp_t e;
        e.name = name;
        e.ctl  = ctl;
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input string name, input logic ack, input logic z,
                        input logic [6:0] opc, input logic [13:0] ctl, input bit retire);
        @(posedge clk);
        #1;
        mem_ack = ack;
        zero    = z;
        opcode  = opc;
        push(name, ctl);
        if (retire) cnt++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cnt   = 0;
        push("reset_held", C_RST);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push("reset_rel", C_RST);
    endtask

    initial begin
        do_reset();

        // R-type, memory ack tied high (ack outside memory states must be ignored)
        step("r_fetch", 1, 0, OpR, C_FACK, 0);
        step("r_dec",   1, 0, OpR, C_DEC,  0);
        step("r_exec",  1, 0, OpR, C_EXR,  0);
        step("r_wb",    1, 0, OpR, C_WBA,  1);

        // ld with three-cycle memory
        step("ld_f0",   0, 0, OpLoad, C_FETCH, 0);
        step("ld_f1",   0, 0, OpLoad, C_FETCH, 0);
        step("ld_f2",   1, 0, OpLoad, C_FACK,  0);
        step("ld_dec",  0, 0, OpLoad, C_DEC,   0);
        step("ld_addr", 0, 0, OpLoad, C_MADDR, 0);
        step("ld_m0",   0, 0, OpLoad, C_MRD,   0);
        step("ld_m1",   0, 0, OpLoad, C_MRD,   0);
        step("ld_m2",   1, 0, OpLoad, C_MRD,   0);
        step("ld_wb",   0, 0, OpLoad, C_WBM,   1);

        // beq taken then not taken
        step("bt_fetch", 1, 0, OpBranch, C_FACK, 0);
        step("bt_dec",   0, 0, OpBranch, C_DEC,  0);
        step("bt_br",    0, 1, OpBranch, C_BRT,  1);
        step("bn_fetch", 1, 1, OpBranch, C_FACK, 0);
        step("bn_dec",   0, 1, OpBranch, C_DEC,  0);
        step("bn_br",    0, 0, OpBranch, C_BRN,  1);

        // sd zero wait
        step("sd_fetch", 1, 0, OpStore, C_FACK,  0);
        step("sd_dec",   1, 0, OpStore, C_DEC,   0);
        step("sd_addr",  1, 0, OpStore, C_MADDR, 0);
        step("sd_wr",    1, 0, OpStore, C_MWR,   1);

        // Illegal opcode parks in TRAP regardless of ack/zero
        step("ill_fetch", 1, 0, OpBad, C_FACK, 0);
        step("ill_dec",   0, 0, OpBad, C_DEC,  0);
        for (int i = 0; i < 22; i++)
            step("ill_trap", i[0], i[1], (i[2] ? OpR : OpBad), C_TRAP, 0);

        do_reset();

        // Store interrupted by reset while waiting for ack
        step("st_fetch", 1, 0, OpStore, C_FACK,  0);
        step("st_dec",   0, 0, OpStore, C_DEC,   0);
        step("st_addr",  0, 0, OpStore, C_MADDR, 0);
        step("st_wr0",   0, 0, OpStore, C_MWR,   0);
        step("st_wr1",   0, 0, OpStore, C_MWR,   0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        cnt   = 0;
        #1;
        check("async_mem_req", 64'(mem_req), 64'd0);
        check("async_mem_we",  64'(mem_we),  64'd0);
        step("st_rst_held", 0, 0, OpImm, C_RST, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push("st_rst_rel", C_RST);

        // 16 addi: narrow counter reads 15 then wraps to 0
        for (int i = 0; i < 16; i++) begin
            step("addi_fetch", 1, 0, OpImm, C_FACK, 0);
            step("addi_dec",   1, 0, OpImm, C_DEC,  0);
            step("addi_exec",  1, 0, OpImm, C_EXI,  0);
            step("addi_wb",    1, 0, OpImm, C_WBA,  1);
        end
        step("addi_end", 0, 0, OpImm, C_FETCH, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
